// File: rtl/lmsm_sequencer.sv
// Load/store-multiple beat sequencer: walks a register bitmap, issuing one memory
// beat per set bit with ascending or descending addressing and registered outputs.
module lmsm_sequencer #(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 8,
  parameter  int STRIDE = 2,
  localparam int RIDX_W = $clog2(NREG),
  localparam int CNT_W  = $clog2(NREG + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic              desc,
  input  logic [NREG-1:0]   mask,
  input  logic [DATA_W-1:0] base_addr,
  input  logic              mem_rdy,
  input  logic              abort,
  output logic              busy,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_addr,
  output logic [RIDX_W-1:0] rf_raddr,
  output logic              rf_we,
  output logic [RIDX_W-1:0] rf_waddr,
  output logic              done,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t            state;
  logic [NREG-1:0]   rem_mask;
  logic              store_q;
  logic              desc_q;

  logic [NREG-1:0]   cur_bit;
  logic [NREG-1:0]   rem_next;
  logic [DATA_W-1:0] addr_next;

  // Lowest set bit when ascending, highest when descending; 0 for an empty map.
  function automatic logic [RIDX_W-1:0] pick(input logic [NREG-1:0] m, input logic d);
    logic [RIDX_W-1:0] r;
    r = '0;
    if (d) begin
      for (int i = 0; i < NREG; i++) begin
        if (m[i]) r = RIDX_W'(i);
      end
    end else begin
      for (int i = NREG - 1; i >= 0; i--) begin
        if (m[i]) r = RIDX_W'(i);
      end
    end
    return r;
  endfunction

  // rf_raddr always holds the current register, so it doubles as the bit to retire.
  always_comb begin
    cur_bit           = '0;
    cur_bit[rf_raddr] = 1'b1;
    rem_next          = rem_mask & ~cur_bit;
    addr_next         = desc_q ? (mem_addr - DATA_W'(STRIDE))
                               : (mem_addr + DATA_W'(STRIDE));
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem_mask  <= '0;
      store_q   <= 1'b0;
      desc_q    <= 1'b0;
      busy      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      rf_raddr  <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      done      <= 1'b0;
      count     <= '0;
    end else begin
      done  <= 1'b0;
      rf_we <= 1'b0;
      if (abort) begin
        // Flush: no beat is accepted on this edge, so count and addresses hold.
        state     <= IDLE;
        busy      <= 1'b0;
        mem_rd_en <= 1'b0;
        mem_wr_en <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              rem_mask <= mask;
              store_q  <= is_store;
              desc_q   <= desc;
              count    <= '0;
              busy     <= 1'b1;
              mem_addr <= base_addr;
              rf_raddr <= pick(mask, desc);
              if (mask != '0) begin
                state     <= RUN;
                mem_wr_en <= is_store;
                mem_rd_en <= !is_store;
              end else begin
                state <= FINISH;
                done  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (mem_rdy) begin
              count    <= count + CNT_W'(1);
              rf_we    <= !store_q;
              rf_waddr <= rf_raddr;
              rem_mask <= rem_next;
              mem_addr <= addr_next;
              rf_raddr <= pick(rem_next, desc_q);
              if (rem_next == '0) begin
                state     <= FINISH;
                done      <= 1'b1;
                mem_rd_en <= 1'b0;
                mem_wr_en <= 1'b0;
              end
            end
          end
          FINISH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: each scenario task drives stimulus and checks
// hand-computed expectations one cycle at a time, sampling 1 ns after the rising edge.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic        desc;
  logic [7:0]  mask;
  logic [15:0] base_addr;
  logic        mem_rdy;
  logic        abort;
  logic        busy;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [15:0] mem_addr;
  logic [2:0]  rf_raddr;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic        done;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  lmsm_sequencer #(.DATA_W(16), .NREG(8), .STRIDE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .desc      (desc),
    .mask      (mask),
    .base_addr (base_addr),
    .mem_rdy   (mem_rdy),
    .abort     (abort),
    .busy      (busy),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .rf_raddr  (rf_raddr),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Control bundle order: {busy, mem_rd_en, mem_wr_en, done, rf_we}
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic st, input logic ds, input logic [7:0] m,
                        input logic [15:0] b);
    is_store  = st;
    desc      = ds;
    mask      = m;
    base_addr = b;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; desc = 1'b0; mask = '0;
    base_addr = '0; mem_rdy = 1'b0; abort = 1'b0;
    #12;
    n_cmp++;
    if ({busy, mem_rd_en, mem_wr_en, done, rf_we} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 00000", {busy, mem_rd_en, mem_wr_en, done, rf_we});
    end
    n_cmp++;
    if ({mem_addr, rf_raddr, rf_waddr, count} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_data: addr=%h raddr=%0d waddr=%0d count=%0d want all 0",
               mem_addr, rf_raddr, rf_waddr, count);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_store_asc();
    logic [2:0]  regs [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
    logic [15:0] adrs [4] = '{16'h0100, 16'h0102, 16'h0104, 16'h0106};
    mem_rdy = 1'b1;
    launch(1'b1, 1'b0, 8'hA5, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({rf_raddr, mem_addr} !== {regs[i], adrs[i]}) begin
        n_bad++;
        $display("FAIL sm_asc_beat%0d: raddr=%0d addr=%h want raddr=%0d addr=%h",
                 i, rf_raddr, mem_addr, regs[i], adrs[i]);
      end
      n_cmp++;
      if ({busy, mem_rd_en, mem_wr_en, done, rf_we} !== 5'b10100) begin
        n_bad++;
        $display("FAIL sm_asc_ctl%0d: got %b want 10100", i,
                 {busy, mem_rd_en, mem_wr_en, done, rf_we});
      end
      step();
    end
    n_cmp++;
    if ({busy, mem_rd_en, mem_wr_en, done, rf_we, count} !== {5'b10010, 4'd4}) begin
      n_bad++;
      $display("FAIL sm_asc_done: ctl=%b count=%0d want ctl=10010 count=4",
               {busy, mem_rd_en, mem_wr_en, done, rf_we}, count);
    end
    step();
    n_cmp++;
    if ({busy, done, count} !== {1'b0, 1'b0, 4'd4}) begin
      n_bad++;
      $display("FAIL sm_asc_idle: busy=%b done=%b count=%0d want 0 0 4", busy, done, count);
    end
  endtask

  task automatic test_load_desc();
    mem_rdy = 1'b1;
    launch(1'b0, 1'b1, 8'h81, 16'h0010);
    n_cmp++;
    if ({mem_addr, rf_raddr, busy, mem_rd_en, mem_wr_en, done, rf_we}
        !== {16'h0010, 3'd7, 5'b11000}) begin
      n_bad++;
      $display("FAIL lm_desc_c1: addr=%h raddr=%0d ctl=%b want 0010 7 11000",
               mem_addr, rf_raddr, {busy, mem_rd_en, mem_wr_en, done, rf_we});
    end
    step();
    n_cmp++;
    if ({mem_addr, rf_raddr, rf_waddr, busy, mem_rd_en, mem_wr_en, done, rf_we}
        !== {16'h000E, 3'd0, 3'd7, 5'b11001}) begin
      n_bad++;
      $display("FAIL lm_desc_c2: addr=%h raddr=%0d waddr=%0d ctl=%b want 000e 0 7 11001",
               mem_addr, rf_raddr, rf_waddr, {busy, mem_rd_en, mem_wr_en, done, rf_we});
    end
    step();
    n_cmp++;
    if ({rf_waddr, busy, mem_rd_en, mem_wr_en, done, rf_we, count}
        !== {3'd0, 5'b10011, 4'd2}) begin
      n_bad++;
      $display("FAIL lm_desc_c3: waddr=%0d ctl=%b count=%0d want 0 10011 2",
               rf_waddr, {busy, mem_rd_en, mem_wr_en, done, rf_we}, count);
    end
    step();
    n_cmp++;
    if ({busy, rf_we, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL lm_desc_c4: busy/rf_we/done=%b want 000", {busy, rf_we, done});
    end
  endtask

  task automatic test_stall();
    mem_rdy = 1'b0;
    launch(1'b1, 1'b0, 8'h0C, 16'h0200);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_rdy = 1'b1;
      n_cmp++;
      if ({rf_raddr, mem_addr, mem_wr_en, done, count} !== {3'd2, 16'h0200, 1'b1, 1'b0, 4'd0}) begin
        n_bad++;
        $display("FAIL stall_hold%0d: raddr=%0d addr=%h wr=%b done=%b count=%0d want 2 0200 1 0 0",
                 i, rf_raddr, mem_addr, mem_wr_en, done, count);
      end
      step();
    end
    n_cmp++;
    if ({rf_raddr, mem_addr, count} !== {3'd3, 16'h0202, 4'd1}) begin
      n_bad++;
      $display("FAIL stall_beat2: raddr=%0d addr=%h count=%0d want 3 0202 1",
               rf_raddr, mem_addr, count);
    end
    step();
    n_cmp++;
    if ({done, mem_wr_en, count} !== {1'b1, 1'b0, 4'd2}) begin
      n_bad++;
      $display("FAIL stall_done: done=%b wr=%b count=%0d want 1 0 2", done, mem_wr_en, count);
    end
    step();
  endtask

  task automatic test_empty_and_wrap();
    mem_rdy = 1'b1;
    launch(1'b0, 1'b0, 8'h00, 16'h1234);
    n_cmp++;
    if ({busy, mem_rd_en, mem_wr_en, done, rf_we, count} !== {5'b10010, 4'd0}) begin
      n_bad++;
      $display("FAIL empty_mask: ctl=%b count=%0d want 10010 0",
               {busy, mem_rd_en, mem_wr_en, done, rf_we}, count);
    end
    step();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL empty_idle: busy/done=%b want 00", {busy, done});
    end
    launch(1'b1, 1'b0, 8'h03, 16'hFFFE);
    n_cmp++;
    if ({mem_addr, rf_raddr} !== {16'hFFFE, 3'd0}) begin
      n_bad++;
      $display("FAIL wrap_b0: addr=%h raddr=%0d want fffe 0", mem_addr, rf_raddr);
    end
    step();
    n_cmp++;
    if ({mem_addr, rf_raddr} !== {16'h0000, 3'd1}) begin
      n_bad++;
      $display("FAIL wrap_b1: addr=%h raddr=%0d want 0000 1", mem_addr, rf_raddr);
    end
    step();
    n_cmp++;
    if ({done, count} !== {1'b1, 4'd2}) begin
      n_bad++;
      $display("FAIL wrap_done: done=%b count=%0d want 1 2", done, count);
    end
    step();
  endtask

  task automatic test_abort();
    int saw;
    mem_rdy = 1'b1;
    launch(1'b0, 1'b0, 8'hFF, 16'h0300);
    step(); step(); step();
    n_cmp++;
    if ({rf_raddr, mem_addr, rf_we, rf_waddr, count} !== {3'd3, 16'h0306, 1'b1, 3'd2, 4'd3}) begin
      n_bad++;
      $display("FAIL abort_pre: raddr=%0d addr=%h we=%b waddr=%0d count=%0d want 3 0306 1 2 3",
               rf_raddr, mem_addr, rf_we, rf_waddr, count);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if ({busy, mem_rd_en, mem_wr_en, done, rf_we, count} !== {5'b00000, 4'd3}) begin
      n_bad++;
      $display("FAIL abort_flush: ctl=%b count=%0d want 00000 3",
               {busy, mem_rd_en, mem_wr_en, done, rf_we}, count);
    end
    saw = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || rf_we || busy) saw++;
    end
    n_cmp++;
    if (saw !== 0) begin
      n_bad++;
      $display("FAIL abort_quiet: %0d cycles with activity want 0", saw);
    end
    abort = 1'b1;
    launch(1'b1, 1'b0, 8'h01, 16'h0000);
    abort = 1'b0;
    n_cmp++;
    if ({busy, mem_wr_en, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL abort_beats_start: busy/wr/done=%b want 000", {busy, mem_wr_en, done});
    end
    launch(1'b1, 1'b0, 8'h01, 16'h0400);
    step();
    n_cmp++;
    if ({busy, done} !== 2'b11) begin
      n_bad++;
      $display("FAIL finish_reached: busy/done=%b want 11", {busy, done});
    end
    mask  = 8'h03;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_cmp++;
    if ({busy, mem_wr_en, mem_rd_en, count} !== {3'b000, 4'd1}) begin
      n_bad++;
      $display("FAIL start_in_finish: busy/wr/rd=%b count=%0d want 000 1",
               {busy, mem_wr_en, mem_rd_en}, count);
    end
  endtask

  task automatic test_async_reset();
    mem_rdy = 1'b1;
    launch(1'b0, 1'b0, 8'h0F, 16'h0500);
    step();
    n_cmp++;
    if ({busy, rf_we, mem_rd_en} !== 3'b111) begin
      n_bad++;
      $display("FAIL arst_pre: busy/we/rd=%b want 111", {busy, rf_we, mem_rd_en});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, mem_rd_en, mem_wr_en, done, rf_we, mem_addr, rf_raddr, rf_waddr, count} !== 31'd0) begin
      n_bad++;
      $display("FAIL arst_clear: ctl=%b addr=%h raddr=%0d waddr=%0d count=%0d want all 0",
               {busy, mem_rd_en, mem_wr_en, done, rf_we}, mem_addr, rf_raddr, rf_waddr, count);
    end
    rst_n = 1'b1;
    launch(1'b1, 1'b0, 8'h06, 16'h0040);
    n_cmp++;
    if ({rf_raddr, mem_addr, mem_wr_en} !== {3'd1, 16'h0040, 1'b1}) begin
      n_bad++;
      $display("FAIL arst_rerun_b0: raddr=%0d addr=%h wr=%b want 1 0040 1",
               rf_raddr, mem_addr, mem_wr_en);
    end
    step();
    n_cmp++;
    if ({rf_raddr, mem_addr} !== {3'd2, 16'h0042}) begin
      n_bad++;
      $display("FAIL arst_rerun_b1: raddr=%0d addr=%h want 2 0042", rf_raddr, mem_addr);
    end
    step();
    n_cmp++;
    if ({done, count} !== {1'b1, 4'd2}) begin
      n_bad++;
      $display("FAIL arst_rerun_done: done=%b count=%0d want 1 2", done, count);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_store_asc();
    test_load_desc();
    test_stall();
    test_empty_and_wrap();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lmsm_sequencer.md
LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 Parameter DATA_W, 16, data/address width in bits.
REQ-002 Parameter NREG, 8, architectural register count and mask width.
REQ-003 Parameter STRIDE, 2, address increment per beat in bytes.
REQ-004 Derived: RIDX_W = clog2(NREG); CNT_W = clog2(NREG+1).
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 CLK  in  1  clock; all state updates on rising edge.
REQ-007 RST_N  in  1  asynchronous active-low reset.
REQ-008 START  in  1  request a multi-register transfer; sampled only in IDLE.
REQ-009 IS_STORE  in  1  1 = store-multiple (RF->mem), 0 = load-multiple (mem->RF).
REQ-010 DESC  in  1  1 = descending mode, 0 = ascending.
REQ-011 MASK  in  NREG  register-select bitmap.
REQ-012 BASE_ADDR  in  DATA_W  first beat address.
REQ-013 MEM_RDY  in  1  memory accepts current beat this cycle.
REQ-014 ABORT  in  1  synchronous pipeline flush.
REQ-015 BUSY  out  1  transfer in progress; used as front-end stall.
REQ-016 MEM_RD_EN / MEM_WR_EN  out  1 each  beat request, load / store.
REQ-017 MEM_ADDR  out  DATA_W  current beat address.
REQ-018 RF_RADDR  out  RIDX_W  register read index for store beats.
REQ-019 RF_WE  out  1  register write strobe for load data.
REQ-020 RF_WADDR  out  RIDX_W  register write index for load data.
REQ-021 DONE  out  1  one-cycle completion pulse.
REQ-022 COUNT  out  CNT_W  beats accepted in current/last transfer.

Function
REQ-023 States SHALL be IDLE, RUN, FINISH.
REQ-024 IDLE & START: latch MASK, BASE_ADDR, IS_STORE, DESC; clear COUNT; go RUN if MASK!=0, else FINISH.
REQ-025 START outside IDLE SHALL be ignored.
REQ-026 In RUN, current register = lowest set bit of remaining mask (ascending) or highest set bit (descending).
REQ-027 In RUN: MEM_WR_EN = IS_STORE, MEM_RD_EN = !IS_STORE; MEM_ADDR = current address; RF_RADDR = current register.
REQ-028 Beat accepted on edge with RUN & MEM_RDY: clear current bit, address += STRIDE (ascending) or -= STRIDE (descending), COUNT += 1.
REQ-029 MEM_RDY=0: all beat outputs SHALL hold stable.
REQ-030 Address arithmetic SHALL wrap modulo 2^DATA_W.
REQ-031 Load beat accepted at edge N: RF_WE=1 and RF_WADDR=that register during cycle after edge N (memory read latency 1).
REQ-032 Acceptance of last set bit: go FINISH; FINISH lasts exactly one cycle with DONE=1, then IDLE.
REQ-033 BUSY = 1 in RUN and FINISH, 0 in IDLE.
REQ-034 MEM_RD_EN, MEM_WR_EN SHALL be 0 outside RUN.
REQ-035 ABORT (any state): next edge -> IDLE; no DONE; pending RF_WE suppressed; COUNT holds.
REQ-036 ABORT and START same cycle in IDLE: ABORT wins, no transfer.
REQ-037 Throughput: one beat per cycle with MEM_RDY held 1; k set bits complete in k+1 cycles after START edge.

Reset
REQ-038 RST_N=0 SHALL immediately force IDLE and all outputs, latched mask, address, COUNT to 0, regardless of state.
REQ-039 First edge with RST_N=1 SHALL sample START normally.

Verification
REQ-040 SM asc, MASK=0xA5, BASE=0x0100, MEM_RDY=1 -> cycles 1-4: RF_RADDR 0,2,5,7, MEM_ADDR 0x0100,0x0102,0x0104,0x0106, MEM_WR_EN=1; cycle 5 DONE=1, COUNT=4.
REQ-041 LM desc, MASK=0x81, BASE=0x0010 -> MEM_ADDR 0x0010 (reg7), 0x000E (reg0); RF_WE cycles 2,3 with RF_WADDR 7,0; DONE cycle 3.
REQ-042 SM asc MASK=0x0C, MEM_RDY low 3 cycles on first beat -> RF_RADDR=2, MEM_ADDR held 3 cycles; DONE 3 cycles late.
REQ-043 MASK=0x00 -> no MEM enables, DONE cycle 1, COUNT=0; wrap: BASE=0xFFFE asc MASK=0x03 -> addresses 0xFFFE, 0x0000.
REQ-044 LM MASK=0xFF, ABORT after 3 beats -> IDLE next edge, no DONE, no RF_WE after abort, COUNT=3; START in FINISH ignored.
REQ-045 RST_N pulsed low mid-RUN asynchronously -> all outputs 0 without clock edge; new START after release runs cleanly.
